// File: rtl/tst2_pkg.sv
// rtl/tst2_pkg.sv - shared defaults and FSM encoding for the tst2 count-pattern pair
package tst2_pkg;

    localparam int TST2_W        = 8;
    localparam int TST2_HOLD     = 256;
    localparam int TST2_LOCK_CNT = 4;
    localparam int TST2_ERRW     = 16;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        TRAIN  = 2'd1,
        LOCKED = 2'd2
    } tst2_state_t;

endpackage

// File: rtl/tst2_sync2.sv
// rtl/tst2_sync2.sv - W-bit two-flop synchronizer, asynchronous active-high reset
module tst2_sync2
    import tst2_pkg::*;
#(
    parameter int W = TST2_W
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_meta;
    logic [W-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/tst2_rx_chk.sv
// rtl/tst2_rx_chk.sv - count-pattern receive checker; TST2_RX_SYNC_EN adds a 2-flop input synchronizer
module tst2_rx_chk
    import tst2_pkg::*;
#(
    parameter int W        = TST2_W,
    parameter int HOLD     = TST2_HOLD,
    parameter int LOCK_CNT = TST2_LOCK_CNT,
    parameter int ERRW     = TST2_ERRW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    d_in,
    input  logic            err_clr,
    output logic            locked,
    output logic            err_pulse,
    output logic [ERRW-1:0] err_cnt,
    output logic [W-1:0]    cur_val
);

    localparam int DW = $clog2(HOLD + 2);
    localparam int GW = $clog2(LOCK_CNT + 1);

    logic [W-1:0]    w_din;
    logic [W-1:0]    r_s;
    logic [W-1:0]    r_p;
    logic [DW-1:0]   r_dwell;
    tst2_state_t     r_state;
    tst2_state_t     w_state_nxt;
    logic [GW-1:0]   r_good_cnt;
    logic [GW-1:0]   w_good_cnt_nxt;
    logic            r_locked;
    logic            r_err_pulse;
    logic [ERRW-1:0] r_err_cnt;
    logic            w_change;
    logic            w_dwell_hold;
    logic            w_good;
    logic            w_stuck;
    logic            w_err;

`ifdef TST2_RX_SYNC_EN
    tst2_sync2 #(.W(W)) u_sync (
        .i_clk (clk),
        .i_rst (rst),
        .i_d   (d_in),
        .o_q   (w_din)
    );
`else
    assign w_din = d_in;
`endif

    assign w_change     = (r_s != r_p);
    assign w_dwell_hold = (r_dwell == DW'(HOLD));
    assign w_good       = w_change && (r_s == r_p + W'(1)) && w_dwell_hold;
    // Stuck fires only on the HOLD -> HOLD+1 transition, so one stall is one event.
    assign w_stuck      = !w_change && w_dwell_hold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s     <= '0;
            r_p     <= '0;
            r_dwell <= '0;
        end else begin
            r_s <= w_din;
            r_p <= r_s;
            if (w_change) begin
                r_dwell <= DW'(1);
            end else if (r_dwell != DW'(HOLD + 1)) begin
                r_dwell <= r_dwell + DW'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_good_cnt_nxt = r_good_cnt;
        w_err          = 1'b0;
        case (r_state)
            SEEK: begin
                if (w_change) begin
                    w_state_nxt    = TRAIN;
                    w_good_cnt_nxt = '0;
                end
            end
            TRAIN: begin
                if (w_good) begin
                    w_good_cnt_nxt = r_good_cnt + GW'(1);
                    if (r_good_cnt == GW'(LOCK_CNT - 1)) begin
                        w_state_nxt = LOCKED;
                    end
                end else if (w_change) begin
                    w_good_cnt_nxt = '0;
                end else if (w_stuck) begin
                    w_state_nxt = SEEK;
                end
            end
            LOCKED: begin
                if (w_change && !w_good) begin
                    w_err          = 1'b1;
                    w_state_nxt    = TRAIN;
                    w_good_cnt_nxt = '0;
                end else if (w_stuck) begin
                    w_err       = 1'b1;
                    w_state_nxt = SEEK;
                end
            end
            default: begin
                w_state_nxt    = SEEK;
                w_good_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= SEEK;
            r_good_cnt  <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_good_cnt  <= w_good_cnt_nxt;
            r_locked    <= (w_state_nxt == LOCKED);
            r_err_pulse <= w_err;
            // Clear has priority over a coincident error; the pulse still shows it.
            if (err_clr) begin
                r_err_cnt <= '0;
            end else if (w_err && (r_err_cnt != {ERRW{1'b1}})) begin
                r_err_cnt <= r_err_cnt + ERRW'(1);
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_cnt   = r_err_cnt;
    assign cur_val   = r_s;

endmodule

// File: tb/tb_tst2_rx_chk.sv
// tb/tb_tst2_rx_chk.sv - scoreboard bench for tst2_rx_chk against a pattern-rule reference model
module tb_tst2_rx_chk;

    localparam int W        = 8;
    localparam int HOLD     = 256;
    localparam int LOCK_CNT = 4;
    // Narrow counter so saturation is reachable in a short run.
    localparam int ERRW     = 3;
    localparam int CNT_MAX  = (1 << ERRW) - 1;
`ifdef TST2_RX_SYNC_EN
    localparam int EXTRA = 2;
`else
    localparam int EXTRA = 0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [W-1:0]    d_in = '0;
    logic            err_clr = 1'b0;
    logic            locked;
    logic            err_pulse;
    logic [ERRW-1:0] err_cnt;
    logic [W-1:0]    cur_val;

    tst2_rx_chk #(.W(W), .HOLD(HOLD), .LOCK_CNT(LOCK_CNT), .ERRW(ERRW)) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .err_clr   (err_clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .cur_val   (cur_val)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cur;
        bit lck;
        bit pls;
        int cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   hist[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    int   g = 0;

    int   m_prev, m_run, m_streak, m_errs;
    bit   m_seeded, m_locked;

    task automatic model_reset();
        m_prev = 0; m_run = 0; m_streak = 0; m_errs = 0;
        m_seeded = 1'b0; m_locked = 1'b0;
        hist.delete();
        for (int i = 0; i <= EXTRA; i++) hist.push_back(0);
    endtask

    // One sampled value through the acquisition rules: runs of HOLD, +1 steps, LOCK_CNT streak.
    task automatic model_step(input int v, input bit clr, output bit err);
        bit ok;
        err = 1'b0;
        if (v != m_prev) begin
            ok = (v == (m_prev + 1) % 256) && (m_run == HOLD);
            m_run = 1;
            if (!m_seeded) begin
                m_seeded = 1'b1;
                m_streak = 0;
            end else if (ok) begin
                if (!m_locked) begin
                    m_streak++;
                    if (m_streak == LOCK_CNT) m_locked = 1'b1;
                end
            end else begin
                err = m_locked;
                m_locked = 1'b0;
                m_streak = 0;
            end
        end else begin
            m_run++;
            if (m_run == HOLD + 1 && m_seeded) begin
                err = m_locked;
                m_locked = 1'b0;
                m_seeded = 1'b0;
            end
        end
        m_prev = v;
        if (clr) m_errs = 0;
        else if (err && m_errs < CNT_MAX) m_errs++;
    endtask

    task automatic drive(input int v, input bit clr);
        exp_t e;
        bit   err;
        @(negedge clk);
        d_in    = W'(v);
        err_clr = clr;
        hist.push_back(v);
        e.cur = hist[1];
        model_step(hist[0], clr, err);
        void'(hist.pop_front());
        e.lck = m_locked;
        e.pls = err;
        e.cnt = m_errs;
        sb_q.push_back(e);
    endtask

    task automatic hold(input int v, input int n);
        repeat (n) drive(v, 1'b0);
    endtask

    task automatic steps(input int n);
        repeat (n) begin
            g = (g + 1) % 256;
            hold(g, HOLD);
        end
    endtask

    task automatic glitch(input int gv, input bit clr);
        drive(gv, 1'b0);
        for (int i = 1; i < HOLD; i++) drive(g, clr && (i == 1 + EXTRA));
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        mon_en  = 1'b0;
        rst     = 1'b1;
        d_in    = '0;
        err_clr = 1'b0;
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_pulse", int'(err_pulse), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_cur_val", int'(cur_val), 0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;
    endtask

    always begin
        @(posedge clk);
        #2;
        if (mon_en) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_empty: no expected entry at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                if (cur_val !== W'(mon_e.cur) || locked !== mon_e.lck ||
                    err_pulse !== mon_e.pls || err_cnt !== ERRW'(mon_e.cnt)) begin
                    errors++;
                    $display("FAIL outputs @%0t: cur_val=%0h/%0h locked=%0b/%0b err_pulse=%0b/%0b err_cnt=%0d/%0d (got/expected)",
                             $time, cur_val, mon_e.cur[W-1:0], locked, mon_e.lck,
                             err_pulse, mon_e.pls, err_cnt, mon_e.cnt);
                end
            end
        end
    end

    initial begin
        int kind;
        int k;

        // Ideal pattern through the FF->00 wrap.
        do_reset();
        g = 8'hFA;
        hold(g, HOLD);
        steps(8);

        // Skip by two while locked, then relock.
        g = (g + 2) % 256;
        hold(g, HOLD);
        steps(5);

        // Stall to 300 clocks, then resume.
        hold(g, 300 - HOLD);
        steps(6);

        // Single-clock glitch, then a glitch with a coincident clear.
        glitch((g + 8'h45) % 256, 1'b0);
        steps(5);
        glitch((g + 8'h45) % 256, 1'b1);
        steps(5);

        // Dwell one short, then one long.
        g = (g + 1) % 256;
        hold(g, HOLD - 1);
        steps(5);
        g = (g + 1) % 256;
        hold(g, HOLD + 1);
        steps(5);

        // Drive err_cnt past saturation.
        repeat (CNT_MAX + 2) begin
            g = (g + 3) % 256;
            hold(g, HOLD);
            steps(4);
        end

        // Asynchronous reset between edges while locked.
        do_reset();
        g = 0;
        hold(g, HOLD);
        steps(6);

        repeat (10) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: steps($urandom_range(1, 3));
                1: begin
                    g = (g + $urandom_range(2, 255)) % 256;
                    hold(g, HOLD);
                end
                2: glitch((g + $urandom_range(2, 255)) % 256, 1'($urandom_range(0, 1)));
                3: begin
                    g = (g + 1) % 256;
                    hold(g, HOLD - 3 + $urandom_range(0, 6));
                end
                4: hold(g, $urandom_range(1, 60));
                default: begin
                    k = $urandom_range(0, HOLD - 1);
                    g = (g + 1) % 256;
                    for (int i = 0; i < HOLD; i++) drive(g, i == k);
                end
            endcase
            steps(5);
        end

        @(posedge clk);
        #3;
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tst2_rx_chk.md
Name: tst2_rx_chk

Overview:
Receive-side checker for the 8-bit count pattern driven by the board test-pattern generator. The generator outputs the upper byte of a free-running 16-bit counter, so each value holds for 256 clocks and then steps by +1 mod 256.
This block samples the pattern pins, acquires lock on the step/dwell sequence, flags every deviation and counts errors. It gives bring-up visibility of pin and board connectivity.

Parameters:
W, 8, pattern width in bits
HOLD, 256, expected dwell of each value in clocks
LOCK_CNT, 4, consecutive good steps needed to enter LOCKED
ERRW, 16, error counter width

Ports:
clk  in  1  system clock, same domain as the pattern generator
rst  in  1  asynchronous, active-high reset
d_in  in  W  pattern pins (generator o7..o0 map to d_in[7:0])
err_clr  in  1  synchronous clear of err_cnt
locked  out  1  high while in LOCKED
err_pulse  out  1  one-clock strobe per detected error
err_cnt  out  ERRW  saturating error count
cur_val  out  W  current sampled pattern value

Behaviour:
- Reset is asynchronous and active-high. While rst is high, all registers and outputs clear immediately: locked=0, err_pulse=0, err_cnt=0, cur_val=0, state=SEEK, dwell=0, good_cnt=0. The same applies when rst asserts mid-operation.
- Sampling: s <= d_in every clk; p <= s. cur_val = s.
- change = (s != p).
- good = change && (s == p+1 mod 2^W) && (dwell == HOLD). Wrap 0xFF->0x00 is good.
- Dwell counter, width clog2(HOLD+2):
  - set to 1 on change;
  - else increments, saturating at HOLD+1;
  - stuck = dwell transitions HOLD -> HOLD+1 (fires once per stall).
- All outputs are registered. Latency from a d_in edge to its locked/err_pulse effect: 2 clocks.
- FSM:
  - SEEK: ignore dwell/value checks. On the first change -> TRAIN, good_cnt=0. This seeds phase alignment.
  - TRAIN:
    - good: good_cnt++. When good_cnt reaches LOCK_CNT -> LOCKED.
    - change && !good: good_cnt=0, stay in TRAIN, no error.
    - stuck: -> SEEK.
  - LOCKED:
    - good: stay.
    - change && !good: error, -> TRAIN, good_cnt=0.
    - stuck: error, -> SEEK.
- Error action: err_pulse=1 for one clock; err_cnt++ saturating at 2^ERRW-1.
- Errors are counted only in LOCKED. Acquisition failures are not errors.
- err_clr: err_cnt <= 0. If err_clr coincides with an error, the clear wins (err_cnt=0) but err_pulse still asserts.
- A glitch (value changes and returns) is two bad changes. In LOCKED this gives 1 error, because the first drops the FSM to TRAIN.

Optional Feature:
TST2_RX_SYNC_EN
- Defined: d_in passes through a 2-flop synchronizer before s, for pins from an asynchronous board. Latency becomes 4 clocks. No other behaviour changes.
- Undefined: direct single register. Latency is 2 clocks.

Decomposition:
- Package tst2_pkg holds:
  - state encoding constants SEEK=2'd0, TRAIN=2'd1, LOCKED=2'd2;
  - default W/HOLD/LOCK_CNT/ERRW values, shared with the pattern generator so both sides agree on HOLD.
- One sub-module, tst2_sync2: a W-bit 2-flop synchronizer with async active-high reset. It is instantiated only under TST2_RX_SYNC_EN.

Test Plan:
1. Ideal pattern from 0x00, each value held 256 clk, reset released at cycle 0 -> SEEK seeds at first change (cycle 256); locked=1 at cycle 1282; err_cnt stays 0 over 0x00..0xFF..0x02 including the wrap.
2. While locked, force value 0x40 to 0x42 (skip) -> one err_pulse, err_cnt=1, locked=0. Relock after 4 further good steps.
3. While locked, hold a value for 300 clk -> stuck error 2 clk after dwell passes 256: err_cnt+1, state SEEK, locked=0. Resume the pattern -> relock after seed plus 4 good steps.
4. While locked, a 1-clock glitch 0x10->0x55->0x10 -> err_cnt=1 (not 2). Assert err_clr in the same cycle as the error -> err_cnt=0, err_pulse=1.
5. Dwell of 255 or 257 clocks on one value while locked -> one error each. Force err_cnt to saturation -> it stays at 0xFFFF.
6. rst asserted asynchronously mid-LOCKED, between clock edges -> all outputs 0 immediately, state SEEK. With TST2_RX_SYNC_EN, rerun scenario 1 -> lock at cycle 1284.
